// File: rtl/sync_fifo_ctrl.sv
// FIFO controller that turns a push/pop stream into write/read controls for a dual-port RAM with a registered read.
// Latency: pop data and pop_valid appear one cycle after an accepted pop.
// Backpressure: a push while full or a pop while empty is dropped and sets a sticky error flag.
module sync_fifo_ctrl #(
    parameter int ram_width          = 8,
    parameter int ram_address        = 10,
    parameter int ram_locations      = 1024,
    parameter int almost_full_level  = 1020,
    parameter int almost_empty_level = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [ram_width-1:0]   push_data,
    input  logic                   pop,
    output logic [ram_width-1:0]   pop_data,
    output logic                   pop_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [ram_address:0]   count,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   ram_write_enable,
    output logic [ram_address-1:0] ram_address_write,
    output logic [ram_width-1:0]   ram_data_in,
    output logic                   ram_read_enable,
    output logic [ram_address-1:0] ram_address_read,
    input  logic [ram_width-1:0]   ram_data_out
);

    localparam int CW = ram_address + 1;
    localparam logic [CW-1:0] LOCATIONS = CW'(ram_locations);
    localparam logic [CW-1:0] AF_LEVEL  = CW'(almost_full_level);
    localparam logic [CW-1:0] AE_LEVEL  = CW'(almost_empty_level);

    // Pointers carry an extra wrap bit above the RAM address bits.
    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;
    logic [CW-1:0] count_nxt;
    logic          wr_acc;
    logic          rd_acc;

    // Acceptance uses the flags registered at the start of the cycle, so a
    // full FIFO rejects a push even if a pop is accepted in the same cycle.
    assign wr_acc = push & ~full;
    assign rd_acc = pop & ~empty;

    // The RAM never sees a same-address read and write: equal addresses only
    // occur when empty (no read) or full (no write), so no bypass is needed.
    assign ram_write_enable  = wr_acc;
    assign ram_address_write = wptr[ram_address-1:0];
    assign ram_data_in       = push_data;
    assign ram_read_enable   = rd_acc;
    assign ram_address_read  = rptr[ram_address-1:0];

    // RAM output is already registered; pop_valid is aligned to it.
    assign pop_data = ram_data_out;

    // Next occupancy: simultaneous accepted push and pop cancel out.
    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CW'(1);
        end
    end

    // Pointers, occupancy, flags and sticky errors all update on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            pop_valid    <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + CW'(1);
            end
            if (rd_acc) begin
                rptr <= rptr + CW'(1);
            end
            count        <= count_nxt;
            empty        <= (count_nxt == '0);
            almost_empty <= (count_nxt <= AE_LEVEL);
            full         <= (count_nxt == LOCATIONS);
            almost_full  <= (count_nxt >= AF_LEVEL);
            pop_valid    <= rd_acc;
            overflow     <= overflow | (push & full);
            underflow    <= underflow | (pop & empty);
        end
    end

    // The wrapped pointer distance must always agree with the occupancy count.
    assert property (@(posedge clk) disable iff (rst) CW'(wptr - rptr) == count);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed and random bench for sync_fifo_ctrl with a behavioural registered-read RAM.
// Latency: checks pop data one cycle after each accepted pop against a scoreboard queue.
// Backpressure: drives pushes into full and pops from empty and checks the sticky errors.
module tb_sync_fifo_ctrl;

    localparam int W     = 8;
    localparam int A     = 10;
    localparam int DEPTH = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic         push;
    logic [W-1:0] push_data;
    logic         pop;
    logic [W-1:0] pop_data;
    logic         pop_valid;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [A:0]   count;
    logic         overflow;
    logic         underflow;
    logic         ram_write_enable;
    logic [A-1:0] ram_address_write;
    logic [W-1:0] ram_data_in;
    logic         ram_read_enable;
    logic [A-1:0] ram_address_read;
    logic [W-1:0] ram_data_out;

    sync_fifo_ctrl #(
        .ram_width(W), .ram_address(A), .ram_locations(DEPTH),
        .almost_full_level(1020), .almost_empty_level(4)
    ) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow),
        .ram_write_enable(ram_write_enable), .ram_address_write(ram_address_write),
        .ram_data_in(ram_data_in), .ram_read_enable(ram_read_enable),
        .ram_address_read(ram_address_read), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM with a one-cycle registered read.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write_enable) mem[ram_address_write] <= ram_data_in;
        if (ram_read_enable)  ram_data_out <= mem[ram_address_read];
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [W-1:0] exp_q[$];
    int           m_count;
    int           m_waddr;
    int           m_raddr;
    logic         m_over;
    logic         m_under;
    int           n_push;
    int           n_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_count = 0;
        m_waddr = 0;
        m_raddr = 0;
        m_over  = 1'b0;
        m_under = 1'b0;
    endtask

    task automatic chk_flags();
        chk("count",        32'(count),        32'(m_count));
        chk("full",         32'(full),         32'(m_count == DEPTH));
        chk("empty",        32'(empty),        32'(m_count == 0));
        chk("almost_full",  32'(almost_full),  32'(m_count >= 1020));
        chk("almost_empty", 32'(almost_empty), 32'(m_count <= 4));
        chk("overflow",     32'(overflow),     32'(m_over));
        chk("underflow",    32'(underflow),    32'(m_under));
    endtask

    // One clock cycle of stimulus: the model decides acceptance from its own
    // occupancy, then both the combinational RAM drive and the registered
    // results are compared.
    task automatic step(input logic p, input logic [W-1:0] d, input logic q);
        logic         wacc;
        logic         racc;
        logic [W-1:0] exp_d;
        wacc  = p && (m_count != DEPTH);
        racc  = q && (m_count != 0);
        exp_d = '0;
        push      = p;
        push_data = d;
        pop       = q;
        #1;
        chk("ram_write_enable", 32'(ram_write_enable), 32'(wacc));
        chk("ram_read_enable",  32'(ram_read_enable),  32'(racc));
        if (wacc) begin
            chk("ram_address_write", 32'(ram_address_write), 32'(m_waddr));
            chk("ram_data_in",       32'(ram_data_in),       32'(d));
        end
        if (racc) chk("ram_address_read", 32'(ram_address_read), 32'(m_raddr));
        if (p && !wacc) m_over  = 1'b1;
        if (q && !racc) m_under = 1'b1;
        if (racc) begin
            exp_d   = exp_q.pop_front();
            m_raddr = (m_raddr + 1) % DEPTH;
            m_count--;
            n_pop++;
        end
        if (wacc) begin
            exp_q.push_back(d);
            m_waddr = (m_waddr + 1) % DEPTH;
            m_count++;
            n_push++;
        end
        @(posedge clk);
        #1;
        chk("pop_valid", 32'(pop_valid), 32'(racc));
        if (racc) chk("pop_data", 32'(pop_data), 32'(exp_d));
        chk_flags();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
        n_push = 0; n_pop = 0;
        model_reset();

        // Reset then idle.
        do_reset();
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_we",        32'(ram_write_enable), 32'd0);
        chk("rst_re",        32'(ram_read_enable),  32'd0);
        chk_flags();

        // Fill completely with i%256, then one rejected push.
        for (int i = 0; i < DEPTH; i++) step(1'b1, W'(i % 256), 1'b0);
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd1024);
        step(1'b1, 8'hEE, 1'b0);
        chk("extra_push_overflow", 32'(overflow), 32'd1);

        // Drain completely, then one rejected pop.
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        chk("drain_empty", 32'(empty), 32'd1);
        step(1'b0, '0, 1'b1);
        chk("extra_pop_underflow", 32'(underflow), 32'd1);

        // Steady state at 500 with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 500; i++) step(1'b1, W'($urandom), 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, W'($urandom), 1'b1);
        chk("steady_count", 32'(count), 32'd500);
        while (m_count > 0) step(1'b0, '0, 1'b1);

        // Random stream of 3000 pushes without overflow; pointers wrap.
        do_reset();
        n_push = 0; n_pop = 0;
        while (n_push < 3000) begin
            step((m_count < DEPTH) && ($urandom_range(0, 99) < 55), W'($urandom),
                 (m_count > 0) && ($urandom_range(0, 99) < 45));
        end
        while (m_count > 0) step(1'b0, '0, 1'b1);
        chk("random_balance", 32'(n_push - n_pop), 32'(count));
        chk("random_pops",    32'(n_pop), 32'd3000);

        // Reset immediately after an accepted pop discards everything.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, W'(i + 1), 1'b0);
        step(1'b0, '0, 1'b1);
        rst = 1'b1; push = 1'b0; pop = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("midrst_count",     32'(count),     32'd0);
        chk("midrst_empty",     32'(empty),     32'd1);
        chk("midrst_pop_valid", 32'(pop_valid), 32'd0);
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("midrst_a5", 32'(pop_data), 32'h0000_00A5);
        step(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Synchronous FIFO controller placed directly in front of dual_port_sync_ram. It converts a push/pop stream interface into that RAM's write/read port controls.
- Owns the write and read pointers, occupancy count, full/empty/almost flags and overflow/underflow error flags.
- Returns RAM read data to the consumer with a pop_valid strobe that matches the RAM's one-cycle registered read latency.

Parameters:
- ram_width, 8, data word width; must equal the RAM's ram_width.
- ram_address, 10, RAM address width; must equal the RAM's ram_address.
- ram_locations, 1024, FIFO depth; must equal 2**ram_address.
- almost_full_level, 1020, almost_full asserts when count >= this value.
- almost_empty_level, 4, almost_empty asserts when count <= this value.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- push  input  1  request to write push_data
- push_data  input  ram_width  write data
- pop  input  1  request to read one word
- pop_data  output  ram_width  read data, valid when pop_valid=1
- pop_valid  output  1  registered; high the cycle after an accepted pop
- full  output  1  registered; count == ram_locations
- empty  output  1  registered; count == 0
- almost_full  output  1  registered; count >= almost_full_level
- almost_empty  output  1  registered; count <= almost_empty_level
- count  output  ram_address+1  registered occupancy, range 0..ram_locations
- overflow  output  1  sticky; set by a rejected push
- underflow  output  1  sticky; set by a rejected pop
- ram_write_enable  output  1  to RAM write_enable
- ram_address_write  output  ram_address  to RAM address_write
- ram_data_in  output  ram_width  to RAM data_in
- ram_read_enable  output  1  to RAM read_enable
- ram_address_read  output  ram_address  to RAM address_read
- ram_data_out  input  ram_width  from RAM data_out

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset values:
  - wptr = 0, rptr = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - pop_valid = 0, overflow = 0, underflow = 0.
- Reset mid-operation: all queued data is discarded.
- RAM reset: drive the RAM's rst from the same rst. The RAM clear is not relied upon; the controller never reads a location it has not written since reset.
- Pointers: wptr and rptr are ram_address+1 bits wide. The low ram_address bits address the RAM. The MSB is a wrap bit; both pointers increment modulo 2**(ram_address+1).
- Accept rules use the registered flags from the start of the cycle:
  - wr_acc = push & ~full
  - rd_acc = pop & ~empty
- RAM drive (combinational):
  - ram_write_enable = wr_acc
  - ram_address_write = wptr[ram_address-1:0]
  - ram_data_in = push_data
  - ram_read_enable = rd_acc
  - ram_address_read = rptr[ram_address-1:0]
- Read latency: the RAM registers its output, so pop_valid <= rd_acc. pop_data = ram_data_out (pass-through). Data is therefore available exactly 1 cycle after the pop is accepted.
- Count update on each clock edge:
  - count + 1 on wr_acc & ~rd_acc
  - count - 1 on rd_acc & ~wr_acc
  - unchanged otherwise
- Flags: full, empty, almost_full and almost_empty are computed from the next count and registered on the same edge as count.
- Simultaneous push and pop:
  - Not full and not empty: both are accepted; count is unchanged.
  - Full: only the pop is accepted; overflow is set; count becomes ram_locations-1.
  - Empty: only the push is accepted; underflow is set; count becomes 1; pop_valid stays 0 next cycle.
- Same-address RAM access: read and write addresses are equal only when the FIFO is empty (no read issued) or full (no write issued). A same-address read/write collision therefore never occurs, and no bypass path is required.
- Error flags: overflow and underflow are cleared only by rst.
- Wrap-around: when a low pointer passes ram_locations-1 it returns to 0 and its wrap bit toggles. Data order is preserved across the wrap.

Test Plan:
- Reset then idle, hold rst=1 for 2 cycles -> empty=1, almost_empty=1, count=0, full=0, pop_valid=0, ram_write_enable=0, ram_read_enable=0.
- Write 1024 words with values i%256, no pops -> almost_full rises the cycle after the 1020th write; full=1 and count=1024 after the 1024th write; an extra push gives ram_write_enable=0, overflow=1, count stays 1024.
- From full, pop 1024 times -> pop_valid follows each pop by 1 cycle; pop_data is 0,1,…,255 repeating; empty=1 after the last pop; one further pop gives underflow=1 and no pop_valid.
- Count=500, hold push=pop=1 for 100 cycles -> count stays 500 throughout; output data is in FIFO order.
- Stream 3000 words with random push/pop, no overflow -> both pointers wrap at least twice; every popped word matches a scoreboard; count always equals pushes minus pops.
- Count=10 with a pop accepted in cycle N, assert rst in cycle N+1 -> count=0, empty=1, pop_valid=0 next cycle; a subsequent push then pop of 0xA5 returns 0xA5.
